// File: rtl/uart_oversampled_receiver.sv
// ============================================================================
// uart_oversampled_receiver
//   8-bit UART receiver, 16x oversampled, majority vote, parity and stop check.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module uart_oversampled_receiver #(
    parameter int CLK_DIV    = 27,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_in,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       parity_error,
    output logic       stop_error,
    output logic       overrun,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    localparam logic [15:0] TICK_LAST = 16'(CLK_DIV - 1);
    // sample_idx holds the index already reached; the tick taken while it
    // equals N-1 is the sample at index N (entry into START is index 0).
    localparam logic [3:0]  IDX_S7    = 4'd6;
    localparam logic [3:0]  IDX_S8    = 4'd7;
    localparam logic [3:0]  IDX_S9    = 4'd8;
    localparam logic [3:0]  IDX_LAST  = 4'd15;

    state_t      state;
    logic        sync1;
    logic        sync2;
    logic [15:0] tick_cnt;
    logic [3:0]  sample_idx;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift_reg;
    logic        s7;
    logic        s8;
    logic        par_err_r;
    logic        tick;
    logic        vote;

    assign tick = (state != S_IDLE) && (tick_cnt == TICK_LAST);
    assign vote = (s7 & s8) | (s7 & sync2) | (s8 & sync2);
    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            sync1        <= 1'b1;
            sync2        <= 1'b1;
            tick_cnt     <= 16'd0;
            sample_idx   <= 4'd0;
            bit_cnt      <= 3'd0;
            shift_reg    <= 8'h00;
            s7           <= 1'b1;
            s8           <= 1'b1;
            par_err_r    <= 1'b0;
            rx_data      <= 8'h00;
            rx_valid     <= 1'b0;
            parity_error <= 1'b0;
            stop_error   <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            sync1 <= rx_in;
            sync2 <= sync1;

            if (state == S_IDLE || tick) begin
                tick_cnt <= 16'd0;
            end else begin
                tick_cnt <= tick_cnt + 16'd1;
            end

            // Plain acknowledge; a frame update below takes precedence.
            if (rx_ack && rx_valid) begin
                rx_valid <= 1'b0;
                overrun  <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (!sync2) begin
                        state      <= S_START;
                        sample_idx <= 4'd0;
                        bit_cnt    <= 3'd0;
                    end
                end
                default: begin
                    if (tick) begin
                        sample_idx <= sample_idx + 4'd1;
                        if (sample_idx == IDX_S7) s7 <= sync2;
                        if (sample_idx == IDX_S8) s8 <= sync2;

                        if (sample_idx == IDX_S9) begin
                            case (state)
                                S_START: begin
                                    if (vote) state <= S_IDLE;
                                end
                                S_DATA: begin
                                    shift_reg <= {vote, shift_reg[7:1]};
                                end
                                S_PARITY: begin
                                    par_err_r <= vote != ((^shift_reg) ^ PARITY_ODD);
                                end
                                S_STOP: begin
                                    rx_data      <= shift_reg;
                                    parity_error <= par_err_r;
                                    stop_error   <= ~vote;
                                    rx_valid     <= 1'b1;
                                    overrun      <= rx_valid && !rx_ack;
                                    state        <= S_IDLE;
                                end
                                default: ;
                            endcase
                        end

                        if (sample_idx == IDX_LAST) begin
                            case (state)
                                S_START:  state <= S_DATA;
                                S_DATA: begin
                                    bit_cnt <= bit_cnt + 3'd1;
                                    if (bit_cnt == 3'd7) state <= S_PARITY;
                                end
                                S_PARITY: state <= S_STOP;
                                default: ;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/uart_oversampled_receiver.md
UART_OVERSAMPLED_RECEIVER -- requirements
Module: uart_oversampled_receiver

Interface
REQ-001 Parameter CLK_DIV, default 27, Clock_In cycles per 1/16-bit sample tick (range 1..65535).
REQ-002 Parameter PARITY_ODD, default 0; 0 = even parity, 1 = odd parity.
REQ-003 Clock_In  input  1  single clock; all state advances on its rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 Rx_In  input  1  serial line; idles high; asynchronous to Clock_In.
REQ-006 Rx_Ack  input  1  consumer acknowledge; clears Rx_Valid.
REQ-007 Rx_Data  output  8  last received data byte, LSB received first.
REQ-008 Rx_Valid  output  1  Rx_Data holds an unacknowledged frame.
REQ-009 Parity_Error  output  1  parity mismatch on the frame in Rx_Data.
REQ-010 Stop_Error  output  1  stop bit sampled low on the frame in Rx_Data.
REQ-011 Overrun  output  1  a frame completed while Rx_Valid was still high.
REQ-012 Busy  output  1  high in every state except IDLE.

Function
REQ-013 Frame SHALL be: 1 start (low), 8 data LSB-first, 1 parity, 1 stop (high); 16 ticks per bit.
REQ-014 Rx_In SHALL pass a 2-flop synchronizer; all decisions use the synchronized value.
REQ-015 Tick counter SHALL count 0..CLK_DIV-1, emit a one-cycle tick at CLK_DIV-1, and wrap to 0; it is held at 0 in IDLE.
REQ-016 States SHALL be IDLE, START, DATA, PARITY, STOP; sample index 0..15 counts ticks within a bit.
REQ-017 IDLE -> START on the first cycle synchronized Rx_In is low; sample index cleared to 0.
REQ-018 Each bit value SHALL be the 2-of-3 majority of samples at indices 7, 8, 9.
REQ-019 START: voted value high -> IDLE (glitch rejected, no flags change); low -> DATA at index 15 wrap.
REQ-020 DATA: 8 bits shifted into an internal register LSB-first; after bit 7 at index 15 -> PARITY.
REQ-021 PARITY: expected = XOR of 8 data bits XOR PARITY_ODD; mismatch recorded; at index 15 -> STOP.
REQ-022 STOP: at the cycle after the index-9 sample, SHALL update Rx_Data, Parity_Error, Stop_Error together and go to IDLE (no wait for end of stop bit).
REQ-023 Rx_Valid SHALL set on the REQ-022 update cycle and clear on the first cycle Rx_Ack is high with no simultaneous update.
REQ-024 Update while Rx_Valid already high (Rx_Ack low) SHALL set Overrun and overwrite Rx_Data and error flags.
REQ-025 Update and Rx_Ack in the same cycle: Rx_Valid stays high, Overrun not set.
REQ-026 Overrun SHALL clear only when Rx_Ack is high with no simultaneous overrun update.
REQ-027 Frames with Stop_Error or Parity_Error SHALL still deliver Rx_Data and set Rx_Valid.
REQ-028 Stop-bit low (break) SHALL not hold the FSM; back in IDLE, a continued low starts a new frame.
REQ-029 Rx_Ack while Rx_Valid low SHALL have no effect.

Reset
REQ-030 Reset low SHALL immediately force state IDLE, counters 0, synchronizer flops 1, Rx_Data 8'h00, Rx_Valid, Parity_Error, Stop_Error, Overrun, Busy all 0.
REQ-031 Reset asserted mid-frame SHALL discard the partial frame; after release, reception restarts on the next low level.
REQ-032 Reset release SHALL take effect on the next Clock_In edge with no extra delay cycles.

Verification (CLK_DIV=1, 16 clocks per bit)
REQ-033 Byte 8'hA5, even parity bit 0, stop high -> Rx_Data=8'hA5, Rx_Valid=1, Parity_Error=0, Stop_Error=0, Rx_Valid rises 10*16+10 clocks (+2 sync) after start edge.
REQ-034 Byte 8'h3C with parity bit 1 (wrong for even) -> Rx_Data=8'h3C, Parity_Error=1; with PARITY_ODD=1 same frame -> Parity_Error=0.
REQ-035 Rx_In low pulse of 4 clocks then high -> Busy pulses, returns IDLE, Rx_Valid stays 0.
REQ-036 Two back-to-back frames 8'h11, 8'h22 with no Rx_Ack -> Rx_Data=8'h22, Overrun=1; Rx_Ack one cycle -> Rx_Valid=0, Overrun=0.
REQ-037 Frame 8'hFF with stop bit low -> Stop_Error=1, Rx_Valid=1; single-sample glitch (1 clock) inside any data bit -> byte still correct.
REQ-038 Reset pulsed low during DATA bit 4 -> all outputs 0 immediately; next clean frame 8'h5A received correctly.
